// File: rtl/rot_pkg.sv
// Shared definitions for the rotation engine address sequencer.
// Holds the mode/direction encodings, the sequencer FSM state enum,
// default field widths, and the helper that folds mode + direction
// into a single clockwise quarter-turn count.
package rot_pkg;

    localparam int ROT_DIM_W     = 16;
    localparam int ROT_ADDR_W    = 32;
    localparam int ROT_PIX_SHIFT = 2;

    typedef enum logic [1:0] {
        ROT_DEG_0   = 2'd0,
        ROT_DEG_90  = 2'd1,
        ROT_DEG_180 = 2'd2,
        ROT_DEG_270 = 2'd3
    } rot_mode_e;

    typedef enum logic {
        ROT_CCW = 1'b0,
        ROT_CW  = 1'b1
    } rot_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } rot_state_e;

    // A CCW turn by N quarters equals a CW turn by (4-N) mod 4 quarters;
    // 2-bit subtraction gives the modulo for free.
    function automatic logic [1:0] eff_rot(input logic [1:0] mode, input logic dir);
        return (dir == ROT_CW) ? mode : (2'd0 - mode);
    endfunction

endpackage

// File: rtl/rot_step_sel.sv
// Combinational table for the destination offset walk.
// Ports:
//   i_rot      effective clockwise quarter turns (0..3)
//   i_h, i_w   source image height / width
//   i_hw       precomputed product H*W
//   o_start    destination offset of source pixel (0,0)
//   o_col_step offset delta when moving one source column right
//   o_row_step offset delta between the first pixels of consecutive rows
// Steps are two's complement in 2*DIM_W bits; addition wraps naturally.
module rot_step_sel
    import rot_pkg::*;
#(
    parameter int DIM_W = ROT_DIM_W
) (
    input  logic [1:0]         i_rot,
    input  logic [DIM_W-1:0]   i_h,
    input  logic [DIM_W-1:0]   i_w,
    input  logic [2*DIM_W-1:0] i_hw,
    output logic [2*DIM_W-1:0] o_start,
    output logic [2*DIM_W-1:0] o_col_step,
    output logic [2*DIM_W-1:0] o_row_step
);
    localparam int OW = 2 * DIM_W;

    logic [OW-1:0] w_h;
    logic [OW-1:0] w_w;
    logic [OW-1:0] w_one;

    assign w_h   = {{DIM_W{1'b0}}, i_h};
    assign w_w   = {{DIM_W{1'b0}}, i_w};
    assign w_one = OW'(1);

    always_comb begin
        o_start    = '0;
        o_col_step = '0;
        o_row_step = '0;
        case (i_rot)
            ROT_DEG_0: begin
                o_start    = '0;
                o_col_step = w_one;
                o_row_step = w_w;
            end
            ROT_DEG_90: begin
                // (r,c) -> c*H + (H-1-r)
                o_start    = w_h - w_one;
                o_col_step = w_h;
                o_row_step = -w_one;
            end
            ROT_DEG_180: begin
                // (r,c) -> (H-1-r)*W + (W-1-c)
                o_start    = i_hw - w_one;
                o_col_step = -w_one;
                o_row_step = -w_w;
            end
            ROT_DEG_270: begin
                // (r,c) -> (W-1-c)*H + r
                o_start    = i_hw - w_h;
                o_col_step = -w_h;
                o_row_step = w_one;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rot_addr_gen.sv
// Rotation engine address sequencer.
// Walks the source image in raster order after a start pulse and emits one
// (source, destination) byte-address pair per pixel under a valid/ready
// handshake; the destination follows the programmed rotation.
// Ports:
//   I_HCLK, I_HRESET          clock, synchronous active-high reset
//   I_START                   start pulse (honoured only when idle)
//   I_SRC_BASE, I_DST_BASE    image base byte addresses
//   I_HEIGHT, I_WIDTH         source dimensions
//   I_MODE, I_DIRECTION       rotation amount and sense
//   I_READY                   DMA accepts the current pair
//   O_VALID, O_SRC_ADDR, O_DST_ADDR, O_LAST   address pair stream
//   O_BUSY, O_DONE, O_ERR     job status (O_ERR on empty image)
//   O_NEW_HEIGHT, O_NEW_WIDTH rotated dimensions, held between jobs
module rot_addr_gen
    import rot_pkg::*;
#(
    parameter int DIM_W     = ROT_DIM_W,
    parameter int ADDR_W    = ROT_ADDR_W,
    parameter int PIX_SHIFT = ROT_PIX_SHIFT
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_SRC_BASE,
    input  logic [ADDR_W-1:0] I_DST_BASE,
    input  logic [DIM_W-1:0]  I_HEIGHT,
    input  logic [DIM_W-1:0]  I_WIDTH,
    input  logic [1:0]        I_MODE,
    input  logic              I_DIRECTION,
    input  logic              I_READY,
    output logic              O_VALID,
    output logic [ADDR_W-1:0] O_SRC_ADDR,
    output logic [ADDR_W-1:0] O_DST_ADDR,
    output logic              O_LAST,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_ERR,
    output logic [DIM_W-1:0]  O_NEW_HEIGHT,
    output logic [DIM_W-1:0]  O_NEW_WIDTH
);
    localparam int OW = 2 * DIM_W;

    rot_state_e        r_state;
    logic [1:0]        r_rot;
    logic [ADDR_W-1:0] r_src_base;
    logic [ADDR_W-1:0] r_dst_base;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_new_h;
    logic [DIM_W-1:0]  r_new_w;
    logic [OW-1:0]     r_src_off;
    logic [OW-1:0]     r_dst_off;
    logic [OW-1:0]     r_row_off;
    logic [OW-1:0]     r_col_step;
    logic [OW-1:0]     r_row_step;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_err_flag;

    logic [OW-1:0]     w_hw;
    logic [OW-1:0]     w_start;
    logic [OW-1:0]     w_col_step;
    logic [OW-1:0]     w_row_step;
    logic              w_row_end;
    logic              w_last;
    logic              w_fire;

    // Only used in PREP, where r_h/r_w are already stable.
    assign w_hw = {{DIM_W{1'b0}}, r_h} * {{DIM_W{1'b0}}, r_w};

    rot_step_sel #(
        .DIM_W (DIM_W)
    ) u_step_sel (
        .i_rot      (r_rot),
        .i_h        (r_h),
        .i_w        (r_w),
        .i_hw       (w_hw),
        .o_start    (w_start),
        .o_col_step (w_col_step),
        .o_row_step (w_row_step)
    );

    assign w_row_end = (r_col == r_w - DIM_W'(1));
    assign w_last    = w_row_end && (r_row == r_h - DIM_W'(1));
    assign w_fire    = r_valid && I_READY;

    assign O_VALID      = r_valid;
    assign O_LAST       = r_valid && w_last;
    assign O_SRC_ADDR   = r_src_base + (ADDR_W'(r_src_off) << PIX_SHIFT);
    assign O_DST_ADDR   = r_dst_base + (ADDR_W'(r_dst_off) << PIX_SHIFT);
    assign O_BUSY       = r_busy;
    assign O_DONE       = r_done;
    assign O_ERR        = r_err;
    assign O_NEW_HEIGHT = r_new_h;
    assign O_NEW_WIDTH  = r_new_w;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_state    <= ST_IDLE;
            r_rot      <= '0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_new_h    <= '0;
            r_new_w    <= '0;
            r_src_off  <= '0;
            r_dst_off  <= '0;
            r_row_off  <= '0;
            r_col_step <= '0;
            r_row_step <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Busy drops one cycle after the done pulse.
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end
                    if (I_START) begin
                        r_src_base <= I_SRC_BASE;
                        r_dst_base <= I_DST_BASE;
                        r_h        <= I_HEIGHT;
                        r_w        <= I_WIDTH;
                        r_rot      <= eff_rot(I_MODE, I_DIRECTION);
                        r_busy     <= 1'b1;
                        r_state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Odd quarter turns swap the axes.
                    r_new_h    <= r_rot[0] ? r_w : r_h;
                    r_new_w    <= r_rot[0] ? r_h : r_w;
                    r_src_off  <= '0;
                    r_dst_off  <= w_start;
                    r_row_off  <= w_start;
                    r_col_step <= w_col_step;
                    r_row_step <= w_row_step;
                    r_row      <= '0;
                    r_col      <= '0;
                    if (r_h == '0 || r_w == '0) begin
                        r_err_flag <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_err_flag <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (w_row_end) begin
                            // New row restarts from the row-start accumulator.
                            r_src_off <= r_src_off + OW'(1);
                            r_col     <= '0;
                            r_row     <= r_row + DIM_W'(1);
                            r_row_off <= r_row_off + r_row_step;
                            r_dst_off <= r_row_off + r_row_step;
                        end else begin
                            r_src_off <= r_src_off + OW'(1);
                            r_col     <= r_col + DIM_W'(1);
                            r_dst_off <= r_dst_off + r_col_step;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_err   <= r_err_flag;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
